sys_clk_monitor: RTL
====================

Name: sys_clk_monitor

Overview:
- Receiving end of the system clock path: runs on the buffered system clock and checks its frequency against a slow reference square wave derived from the crystal.
- Counts i_sys_clk cycles between reference rising edges and compares each count to an expected value within a tolerance.
- Reports lock and a sticky loss-of-lock fault to reset sequencing and status logic.

Parameters:
- EXP_COUNT, 50250: expected i_sys_clk cycles per reference period (50.25 MHz / 1 kHz).
- TOLERANCE, 64: allowed ± deviation from EXP_COUNT, inclusive.
- LOCK_WINDOWS, 4: consecutive good periods required to declare lock.
- CNT_W, 20: counter and o_last_count width. Must satisfy 2^CNT_W > EXP_COUNT+TOLERANCE+1.

Ports:
- i_sys_clk  input  1  system clock; the only clock in the block.
- i_rst  input  1  synchronous, active-high reset.
- i_ref  input  1  asynchronous reference square wave from the crystal domain.
- i_fault_clr  input  1  single-cycle pulse that clears o_fault.
- o_locked  output  1  high while the measured frequency is within tolerance.
- o_fault  output  1  sticky; set when lock is lost.
- o_last_count  output  CNT_W  most recent period measurement.
- o_count_valid  output  1  one-cycle pulse when o_last_count updates.

Behaviour:
- Reset is synchronous and active-high; all flops clear on an i_sys_clk edge with i_rst=1. Reset values: o_locked=0, o_fault=0, o_last_count=0, o_count_valid=0, state=ARM, good_run=0, cnt=0, synchroniser flops=0.
- Input path: i_ref passes through 2 synchroniser flops (s1, s2), then a history flop s3. A rising edge is detected in the cycle where s2=1 and s3=0.
- Latency: o_count_valid pulses on the 3rd i_sys_clk edge after i_ref is first sampled high.
- Counter: on a detected edge, cnt <= 0; otherwise cnt <= cnt+1. Period value = cnt+1 at the edge, i.e. the number of cycles between successive edges.
- Timeout: if cnt+1 reaches EXP_COUNT+TOLERANCE+1 with no edge, this counts as a bad measurement:
  - o_last_count <= EXP_COUNT+TOLERANCE+1 and o_count_valid pulses;
  - cnt <= 0; state -> ARM.
- Good measurement: EXP_COUNT-TOLERANCE <= period <= EXP_COUNT+TOLERANCE, unsigned, with no underflow when TOLERANCE > EXP_COUNT (lower bound floors at 0).
- State ARM: waits for the first edge.
  - An edge realigns the counter and moves to MEASURE.
  - No measurement is reported; o_count_valid stays 0.
  - A false edge 2 cycles after reset (i_ref high at reset release) is accepted as the alignment edge.
- State MEASURE: each edge latches o_last_count and pulses o_count_valid.
  - Good: good_run++. Reaching LOCKED_WINDOWS moves to LOCKED and sets o_locked=1 in the same update.
  - Bad: good_run <= 0; stay in MEASURE.
  - Timeout: -> ARM.
- State LOCKED: good measurements keep o_locked=1. A bad measurement or a timeout causes, in the same update:
  - o_locked <= 0, o_fault <= 1, good_run <= 0;
  - next state MEASURE on a bad measurement, ARM on a timeout.
- Faults outside LOCKED: bad measurements in MEASURE before lock is first reached do not set o_fault.
- Fault clear: i_fault_clr clears o_fault next cycle. If a set and a clear occur in the same cycle, set wins and o_fault stays 1. Clearing has no effect on o_locked or state.
- Edge vs timeout: if an edge and the timeout threshold coincide in the same cycle, the edge wins and the measurement is evaluated normally.
- o_last_count holds its value between updates.
- Reset mid-measurement discards the partial count and returns to ARM. The first measurement after reset needs two edges.

Test Plan (bench params EXP_COUNT=100, TOLERANCE=4, LOCK_WINDOWS=4, CNT_W=8):
- Lock acquisition: i_ref period 100 cycles, 6 edges.
  - No valid pulse on edge 1.
  - o_count_valid on edges 2–6 with o_last_count=100.
  - o_locked rises with the valid pulse of edge 5 (4th good period); o_fault=0.
- Tolerance bounds: periods 96, 104, 95, 105.
  - 96 and 104 increment good_run.
  - 95 and 105 reset good_run to 0.
  - No lock; o_fault stays 0.
- Loss of lock: after lock, one period of 110.
  - o_last_count=105 via timeout; o_locked=0; o_fault=1; state ARM.
  - Then four periods of 100 after re-alignment give o_locked=1 again, with o_fault still 1.
- Fault clear: i_fault_clr pulse with o_fault=1 gives o_fault=0 next cycle.
  - Repeat with i_fault_clr in the same cycle a new loss-of-lock sets the fault: o_fault must stay 1.
- Missing reference: after lock, hold i_ref low.
  - o_count_valid pulses with o_last_count=105 at 105 cycles after the last edge; o_locked=0; o_fault=1.
  - No further valid pulses while i_ref stays low.
- Reset mid-operation: i_rst=1 for 1 cycle mid-period while locked.
  - All outputs return to 0 next cycle.
  - With i_ref held high through reset, the false edge only aligns; the first o_count_valid comes on the following real edge.

Source files
------------

// File: rtl/sys_clk_monitor.sv
// System clock frequency monitor: counts i_sys_clk cycles per reference period
// and reports lock plus a sticky loss-of-lock fault.
module sys_clk_monitor #(
  parameter int EXP_COUNT    = 50250,
  parameter int TOLERANCE    = 64,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 20
) (
  input  logic             i_sys_clk,
  input  logic             i_rst,
  input  logic             i_ref,
  input  logic             i_fault_clr,
  output logic             o_locked,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_last_count,
  output logic             o_count_valid
);

  localparam int GR_W   = $clog2(LOCK_WINDOWS + 1);
  // Lower bound floors at zero so a wide tolerance cannot wrap around
  localparam int LO_INT = (EXP_COUNT > TOLERANCE) ? (EXP_COUNT - TOLERANCE) : 0;

  localparam logic [CNT_W-1:0] LO_BOUND    = CNT_W'(LO_INT);
  localparam logic [CNT_W-1:0] HI_BOUND    = CNT_W'(EXP_COUNT + TOLERANCE);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(EXP_COUNT + TOLERANCE + 1);
  localparam logic [GR_W-1:0]  LOCK_GOAL   = GR_W'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [GR_W-1:0]  good_run;
  logic [GR_W-1:0]  good_run_nxt;
  logic             locked_nxt;
  logic             fault_nxt;
  logic [CNT_W-1:0] last_count_nxt;
  logic             valid_nxt;

  logic             edge_det;
  logic [CNT_W-1:0] period;
  logic             in_range;
  logic             timeout;

  assign edge_det = s2 & ~s3;
  assign period   = cnt + 1'b1;
  assign in_range = (period >= LO_BOUND) && (period <= HI_BOUND);
  // A real edge on the threshold cycle takes priority over the timeout
  assign timeout  = !edge_det && (period == TIMEOUT_VAL);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = edge_det ? '0 : period;
    good_run_nxt   = good_run;
    locked_nxt     = o_locked;
    fault_nxt      = o_fault & ~i_fault_clr;
    last_count_nxt = o_last_count;
    valid_nxt      = 1'b0;

    case (state)
      ARM: begin
        if (edge_det) begin
          state_nxt = MEASURE;
        end else if (period == TIMEOUT_VAL) begin
          cnt_nxt = '0;
        end
      end

      MEASURE: begin
        if (edge_det) begin
          valid_nxt      = 1'b1;
          last_count_nxt = period;
          if (in_range) begin
            good_run_nxt = good_run + 1'b1;
            if (good_run + 1'b1 == LOCK_GOAL) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            good_run_nxt = '0;
          end
        end else if (timeout) begin
          valid_nxt      = 1'b1;
          last_count_nxt = TIMEOUT_VAL;
          cnt_nxt        = '0;
          good_run_nxt   = '0;
          state_nxt      = ARM;
        end
      end

      LOCKED: begin
        if (edge_det) begin
          valid_nxt      = 1'b1;
          last_count_nxt = period;
          if (!in_range) begin
            locked_nxt   = 1'b0;
            fault_nxt    = 1'b1;
            good_run_nxt = '0;
            state_nxt    = MEASURE;
          end
        end else if (timeout) begin
          valid_nxt      = 1'b1;
          last_count_nxt = TIMEOUT_VAL;
          cnt_nxt        = '0;
          locked_nxt     = 1'b0;
          fault_nxt      = 1'b1;
          good_run_nxt   = '0;
          state_nxt      = ARM;
        end
      end

      default: begin
        state_nxt = ARM;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= ARM;
      cnt           <= '0;
      good_run      <= '0;
      o_locked      <= 1'b0;
      o_fault       <= 1'b0;
      o_last_count  <= '0;
      o_count_valid <= 1'b0;
    end else begin
      s1            <= i_ref;
      s2            <= s1;
      s3            <= s2;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      good_run      <= good_run_nxt;
      o_locked      <= locked_nxt;
      o_fault       <= fault_nxt;
      o_last_count  <= last_count_nxt;
      o_count_valid <= valid_nxt;
    end
  end

endmodule
